// File: rtl/zero_flag_detector.sv
// zero_flag_detector: zero flag for the ALU result bus.
// zero_comb is a flat NOR of the result for the per-operation flag muxes.
// zero / nonzero_mask / out_valid come from an OR-reduction tree.
// With PIPELINE=1 there is a register after every tree level.
// With PIPELINE=0 the tree is combinational and feeds one output register.

// One reduction node: OR of FANIN child bits.
module zfd_or_node #(
    parameter int FANIN = 4
) (
    input  logic [FANIN-1:0] slice,
    output logic             any_set
);
    assign any_set = |slice;
endmodule

module zero_flag_detector #(
    parameter int   WIDTH    = 64,
    parameter int   FANIN    = 4,
    parameter int   PIPELINE = 1,
    localparam int  NGRP     = (WIDTH + FANIN - 1) / FANIN
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data,
    output logic             zero_comb,
    output logic             out_valid,
    output logic             zero,
    output logic [NGRP-1:0]  nonzero_mask
);

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Node count of tree level l (level 0 has one node per FANIN-bit slice).
    function automatic int level_nodes(input int l);
        int n;
        n = ceil_div(WIDTH, FANIN);
        for (int i = 0; i < l; i++) n = ceil_div(n, FANIN);
        return n;
    endfunction

    // Levels until a single root remains; never fewer than one.
    function automatic int tree_levels(input int w, input int f);
        int n;
        int lv;
        n  = ceil_div(w, f);
        lv = 1;
        for (int i = 0; i < 32; i++) begin
            if (n > 1) begin
                n  = ceil_div(n, f);
                lv = lv + 1;
            end
        end
        return lv;
    endfunction

    localparam int LEVELS = tree_levels(WIDTH, FANIN);
    localparam int STAGES = (PIPELINE != 0) ? LEVELS : 1;

    // Flat NOR: no clock, no reset, no qualifier.
    assign zero_comb = ~|data;

    // vld_pipe[s] is the valid bit entering register stage s.
    logic [STAGES:0] vld_pipe;
    assign vld_pipe[0] = in_valid;

    // Valid chain: same depth as the data path, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_pipe[STAGES:1] <= '0;
        else          vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : lv
        localparam int NN = level_nodes(l);
        localparam int NI = (l == 0) ? WIDTH : level_nodes(l - 1);

        logic [NI-1:0]       src;
        logic [NN*FANIN-1:0] din;
        logic [NN-1:0]       ory;

        if (l == 0) begin : g_src_data
            assign src = data;
        end else if (PIPELINE != 0) begin : g_src_reg
            assign src = lv[l-1].g_reg.r;
        end else begin : g_src_comb
            assign src = lv[l-1].ory;
        end

        // Zero-pad the top slice so it cannot set any OR.
        always_comb begin
            din          = '0;
            din[NI-1:0]  = src;
        end

        for (genvar n = 0; n < NN; n++) begin : node
            zfd_or_node #(.FANIN(FANIN)) u_node (
                .slice   (din[n*FANIN +: FANIN]),
                .any_set (ory[n])
            );
        end

        if (PIPELINE != 0) begin : g_reg
            logic [NN-1:0]   r;
            logic [NGRP-1:0] mq;
            logic [NGRP-1:0] mq_d;

            // The level-0 group ORs ride alongside the tree to stay aligned with zero.
            if (l == 0) begin : g_mq0
                assign mq_d = ory;
            end else begin : g_mqn
                assign mq_d = lv[l-1].g_reg.mq;
            end

            // Level register: loads only for a valid result, holds otherwise.
            // The root resets to "nonzero" so the zero output reads 0 in reset.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r  <= (l == LEVELS - 1) ? {NN{1'b1}} : {NN{1'b0}};
                    mq <= '0;
                end else if (vld_pipe[l]) begin
                    r  <= ory;
                    mq <= mq_d;
                end
            end
        end
    end

    if (PIPELINE != 0) begin : g_out_pipe
        assign out_valid    = vld_pipe[STAGES];
        assign zero         = ~lv[LEVELS-1].g_reg.r[0];
        assign nonzero_mask = lv[LEVELS-1].g_reg.mq;
    end else begin : g_out_flat
        logic            zero_r;
        logic [NGRP-1:0] mask_r;

        // Single output register behind the combinational tree.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                zero_r <= 1'b0;
                mask_r <= '0;
            end else if (vld_pipe[0]) begin
                zero_r <= ~lv[LEVELS-1].ory[0];
                mask_r <= lv[0].ory;
            end
        end

        assign out_valid    = vld_pipe[STAGES];
        assign zero         = zero_r;
        assign nonzero_mask = mask_r;
    end

endmodule

// File: tb/tb_zero_flag_detector.sv
// Bench for zero_flag_detector: default 64/4/pipelined instance plus a
// 10/4/flat instance. Expected flags are queued at drive time with their
// due cycle and compared every negedge; idle cycles check hold values.
module tb_zero_flag_detector;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_valid2;
    logic [63:0] data;
    logic [9:0]  data2;
    logic        zero_comb, out_valid, zero;
    logic [15:0] nonzero_mask;
    logic        zero_comb2, out_valid2, zero2;
    logic [2:0]  nonzero_mask2;

    zero_flag_detector dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .data         (data),
        .zero_comb    (zero_comb),
        .out_valid    (out_valid),
        .zero         (zero),
        .nonzero_mask (nonzero_mask)
    );

    zero_flag_detector #(.WIDTH(10), .FANIN(4), .PIPELINE(0)) dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid2),
        .data         (data2),
        .zero_comb    (zero_comb2),
        .out_valid    (out_valid2),
        .zero         (zero2),
        .nonzero_mask (nonzero_mask2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        z;
        logic [15:0] m;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb2[$];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic        last_z = 1'b0, last_z2 = 1'b0;
    logic [15:0] last_m = '0, last_m2 = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mask64(input logic [63:0] d);
        logic [15:0] m;
        for (int g = 0; g < 16; g++) m[g] = |d[4*g +: 4];
        return m;
    endfunction

    function automatic logic [15:0] mask10(input logic [9:0] d);
        logic [11:0] p;
        logic [15:0] m;
        p = {2'b00, d};
        m = '0;
        for (int g = 0; g < 3; g++) m[g] = |p[4*g +: 4];
        return m;
    endfunction

    task automatic drive(input logic v, input logic [63:0] d);
        @(posedge clk);
        #1;
        in_valid  = v;
        data      = d;
        in_valid2 = 1'b0;
        if (v && reset_n) sb.push_back('{z: (d == 64'd0), m: mask64(d), due: cyc + 3});
        #1;
        check("zero_comb", zero_comb, d == 64'd0);
    endtask

    task automatic drive2(input logic v, input logic [9:0] d);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid2 = v;
        data2     = d;
        if (v && reset_n) sb2.push_back('{z: (d == 10'd0), m: mask10(d), due: cyc + 1});
        #1;
        check("zero_comb2", zero_comb2, d == 10'd0);
    endtask

    // Output monitor for both instances.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb.delete();
                sb2.delete();
                last_z  = 1'b0;
                last_m  = '0;
                last_z2 = 1'b0;
                last_m2 = '0;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("out_valid", out_valid, 1);
                check("zero", zero, sb[0].z);
                check("nonzero_mask", nonzero_mask, sb[0].m);
                last_z = sb[0].z;
                last_m = sb[0].m;
                void'(sb.pop_front());
            end else begin
                check("out_valid_idle", out_valid, 0);
                check("zero_hold", zero, last_z);
                check("mask_hold", nonzero_mask, last_m);
            end
            if (sb2.size() > 0 && sb2[0].due == cyc) begin
                check("out_valid2", out_valid2, 1);
                check("zero2", zero2, sb2[0].z);
                check("nonzero_mask2", nonzero_mask2, sb2[0].m);
                last_z2 = sb2[0].z;
                last_m2 = sb2[0].m;
                void'(sb2.pop_front());
            end else begin
                check("out_valid2_idle", out_valid2, 0);
                check("zero2_hold", zero2, last_z2);
                check("mask2_hold", nonzero_mask2, last_m2);
            end
        end
    end

    initial begin
        logic [63:0] ones;
        ones      = '1;
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        data      = '0;
        data2     = '0;
        #1 reset_n = 1'b0;

        // Reset held with random data and in_valid high.
        repeat (4) drive(1'b1, {$urandom(), $urandom()});
        drive(1'b1, 64'd0);
        drive(1'b0, 64'd0);
        reset_n = 1'b1;

        // Single zero result.
        drive(1'b1, 64'd0);
        repeat (4) drive(1'b0, 64'd0);

        // Walking one, back to back.
        for (int k = 0; k < 64; k++) drive(1'b1, 64'd1 << k);
        repeat (4) drive(1'b0, 64'd0);

        // Mixed stream with a bubble carrying nonzero garbage.
        drive(1'b1, 64'd0);
        drive(1'b0, {$urandom(), $urandom()} | 64'd1);
        drive(1'b1, ones);
        drive(1'b1, 64'h8000_0000_0000_0000);
        drive(1'b1, 64'd0);
        repeat (4) drive(1'b0, 64'd0);

        // Mid-flight reset: two results in flight are discarded.
        drive(1'b1, 64'd0);
        drive(1'b1, 64'd5);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #5;
        reset_n  = 1'b1;
        repeat (2) drive(1'b0, 64'd0);
        drive(1'b1, 64'd0);
        repeat (4) drive(1'b0, 64'd0);

        // Narrow, padded, single-register instance.
        drive2(1'b1, 10'h200);
        drive2(1'b1, 10'h000);
        drive2(1'b1, 10'h001);
        drive2(1'b0, 10'h3FF);
        repeat (3) drive2(1'b0, 10'h000);

        check("scoreboard_drained", sb.size() + sb2.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
